// File: rtl/gfx_strip_rmw.sv
// Single-line strip cache with read-modify-write of a pixel bit field.
// A request carries a strip byte address, a bit span [mb..me] and a colour;
// the span is combined into the cached strip with a raster op. Misses write
// back a dirty line, then fill from memory. flush_i writes back a dirty line.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_*            pixel write request (valid/ready handshake)
//   flush_i          level request to write back the cached strip
//   mem_*            single-outstanding memory cycle, ack is a one-cycle pulse
//   busy_o           high whenever the controller is not idle
module gfx_strip_rmw #(
  parameter int unsigned SW = 256,
  parameter int unsigned BN = $clog2(SW) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [31:0]   req_addr_i,
  input  logic [BN:0]   req_mb_i,
  input  logic [BN:0]   req_me_i,
  input  logic [31:0]   req_color_i,
  input  logic [1:0]    req_rop_i,
  input  logic          flush_i,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [SW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [SW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam logic [31:0] OffMask = 32'(SW / 8) - 32'd1;

  typedef enum logic [2:0] {StIdle, StWb, StRd, StMerge, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     tag_q, tag_d;
  logic [SW-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            dirty_q, dirty_d;
  // Latched request
  logic [31:0]     rtag_q, rtag_d;
  logic [BN:0]     mb_q, mb_d;
  logic [BN:0]     me_q, me_d;
  logic [31:0]     color_q, color_d;
  logic [1:0]      rop_q, rop_d;
  // Registered memory interface
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [SW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [31:0]     req_tag;
  logic            hit;
  logic [SW-1:0]   mask, color_ext, field;

  assign req_tag = req_addr_i & ~OffMask;
  assign hit     = valid_q && (tag_q == req_tag);

  // Combinational on rst_n so ready stays low while reset is held.
  assign req_ready_o = rst_n && (state_q == StIdle) && !flush_i;
  assign busy_o      = (state_q != StIdle);
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_comb begin
    mask      = '0;
    color_ext = '0;
    for (int i = 0; i < int'(SW); i++) begin
      mask[i] = (i >= int'(mb_q)) && (i <= int'(me_q));
    end
    color_ext[31:0] = color_q;
    field = (color_ext << mb_q) & mask;
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    rtag_d      = rtag_q;
    mb_d        = mb_q;
    me_d        = me_q;
    color_d     = color_q;
    rop_d       = rop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          if (dirty_q) state_d = StFlush;
        end else if (req_valid_i) begin
          // An empty span (me < mb) is accepted and dropped.
          if (req_me_i >= req_mb_i) begin
            rtag_d  = req_tag;
            mb_d    = req_mb_i;
            me_d    = req_me_i;
            color_d = req_color_i;
            rop_d   = req_rop_i;
            if (hit)          state_d = StMerge;
            else if (dirty_q) state_d = StWb;
            else              state_d = StRd;
          end
        end
      end
      StWb, StFlush: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = tag_q;
          mem_wdata_d = data_q;
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == StWb) begin
            state_d = StRd;
          end else begin
            dirty_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StRd: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rtag_q;
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          data_d    = mem_rdata_i;
          tag_d     = rtag_q;
          valid_d   = 1'b1;
          dirty_d   = 1'b0;
          state_d   = StMerge;
        end
      end
      StMerge: begin
        unique case (rop_q)
          2'd0: data_d = (data_q & ~mask) | field;
          2'd1: data_d = data_q & (field | ~mask);
          2'd2: data_d = data_q | field;
          2'd3: data_d = data_q ^ field;
          default: data_d = data_q;
        endcase
        dirty_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      dirty_q     <= 1'b0;
      rtag_q      <= '0;
      mb_q        <= '0;
      me_q        <= '0;
      color_q     <= '0;
      rop_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rtag_q      <= rtag_d;
      mb_q        <= mb_d;
      me_q        <= me_d;
      color_q     <= color_d;
      rop_q       <= rop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: doc/gfx_strip_rmw.md
GFX_STRIP_RMW -- requirements
Module: gfx_strip_rmw

Interface
REQ-001 SHALL have parameter SW, default 256, strip width in bits (32/64/128/256).
REQ-002 SHALL have parameter BN, default $clog2(SW)-1, bit-index width minus one.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  pixel write request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid&ready.
REQ-007 SHALL have port req_addr_i  input  32  strip byte address from address calculator.
REQ-008 SHALL have port req_mb_i  input  BN+1  first pixel bit in strip.
REQ-009 SHALL have port req_me_i  input  BN+1  last pixel bit in strip, inclusive.
REQ-010 SHALL have port req_color_i  input  32  pixel colour, LSB-aligned.
REQ-011 SHALL have port req_rop_i  input  2  raster op: 0 copy, 1 AND, 2 OR, 3 XOR.
REQ-012 SHALL have port flush_i  input  1  level request to write back the cached strip.
REQ-013 SHALL have port mem_req_o  output  1  memory cycle request.
REQ-014 SHALL have port mem_we_o  output  1  1 write, 0 read.
REQ-015 SHALL have port mem_addr_o  output  32  strip-aligned memory address.
REQ-016 SHALL have port mem_wdata_o  output  SW  write data.
REQ-017 SHALL have port mem_ack_i  input  1  one-cycle completion pulse.
REQ-018 SHALL have port mem_rdata_i  input  SW  read data, valid with mem_ack_i.
REQ-019 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL hold one strip line: tag[31:0], data[SW-1:0], valid, dirty.
REQ-021 SHALL form strip tag as req_addr_i with low log2(SW/8) bits cleared; mem_addr_o always aligned.
REQ-022 SHALL use states IDLE, WB, RD, MERGE, FLUSH.
REQ-023 SHALL assert req_ready_o only in IDLE and only when flush_i is low.
REQ-024 SHALL, on accept with valid & tag match (hit), latch request and go to MERGE; line updated next edge; back in IDLE, ready, one cycle after that (2-cycle hit throughput).
REQ-025 SHALL, on accept with miss and dirty line, go WB (write old line to old tag), then RD, then MERGE.
REQ-026 SHALL, on accept with miss and clean/invalid line, go RD directly.
REQ-027 SHALL assert mem_req_o the cycle after entering WB/RD/FLUSH and hold it, with mem_addr_o/mem_we_o/mem_wdata_o stable, until the cycle mem_ack_i is sampled high; mem_req_o low the next cycle.
REQ-028 SHALL ignore mem_ack_i when mem_req_o is low.
REQ-029 SHALL, on RD ack, load data from mem_rdata_i, set tag, valid=1, dirty=0.
REQ-030 SHALL in MERGE build mask with bits mb..me set; field = (color << mb) & mask, color bits beyond 32 zero.
REQ-031 SHALL apply rop to masked bits only: copy d=(d&~mask)|field; AND d&(field|~mask); OR d|field; XOR d^field; set dirty=1.
REQ-032 SHALL treat me<mb as a no-op request: accepted, no memory traffic, line unchanged.
REQ-033 SHALL, on flush_i high in IDLE with dirty line, go FLUSH, write line, clear dirty, return IDLE; clean/invalid line: no traffic, stays IDLE.
REQ-034 SHALL give flush_i priority over req_valid_i when both high in IDLE.
REQ-035 SHALL keep line valid after flush (invalidation only by reset).

Reset
REQ-036 SHALL on rst_n low immediately force state IDLE, valid=0, dirty=0, mem_req_o=0, mem_we_o=0, req_ready_o=0 while low, busy_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-037 SHALL abandon any in-flight memory cycle on reset; a later stray mem_ack_i is ignored per REQ-028.
REQ-038 SHALL assert req_ready_o the first cycle after rst_n deasserts.

Verification
REQ-039 Cold write addr 0x1000, mb=8, me=15, color 0xAB, copy, memory returns all zero -> one read at 0x1000, line bits[15:8]=0xAB, no write.
REQ-040 Hit addr 0x1010 (same 32-byte strip), mb=0, me=3, color 0xF, XOR -> no memory traffic, bits[3:0] inverted, ready again two cycles after accept.
REQ-041 Miss to 0x2000 with dirty line -> write to 0x1000 with merged data first, then read 0x2000.
REQ-042 flush_i and req_valid_i together, dirty line -> write issued, request not accepted until IDLE and flush_i low.
REQ-043 mem_ack_i delayed 5 cycles -> mem_req_o/addr/data stable all 5 cycles, drop the cycle after ack.
REQ-044 rst_n low during RD, ack arrives after reset -> ignored, valid=0, next request re-reads.
